// File: rtl/adexp_pkg.sv
// Shared types and constants for the AdEx parameter loader.
// PARAM_RESET holds the power-on values of the neuron parameter registers.
package adexp_pkg;

    localparam int PARAM_W    = 16;
    localparam int MAX_PARAMS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_A,
        ST_GOT_H,
        ST_CHK_W,
        ST_DISCARD
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_ADDR    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_CHK     = 2'd3
    } err_t;

    // Entry i is the reset value of parameter register i (a, b, tau_w, V_T, ...).
    localparam logic [PARAM_W-1:0] PARAM_RESET [MAX_PARAMS] = '{
        16'h0040, 16'h0800, 16'h0C80, 16'hFC00,
        16'h0200, 16'h0010, 16'h0064, 16'h0A00,
        16'h0001, 16'h0002, 16'h0003, 16'h0004,
        16'h0005, 16'h0006, 16'h0007, 16'h0008
    };

    // An address byte is valid when bit7 is set and the index fits the register file.
    function automatic logic addr_ok(input logic [7:0] b, input int num_params);
        return b[7] && (int'(b[3:0]) < num_params);
    endfunction

endpackage

// File: rtl/adexp_strobe_sync.sv
// Two-flop synchroniser for an asynchronous pin strobe followed by a
// rising-edge detector; rise is a one-cycle pulse per pin rising edge.
module adexp_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [2:0] shift;

    // Shift the pin through two sync stages plus one history stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            shift <= {shift[1:0], async_in};
        end
    end

    assign rise = shift[1] & ~shift[2];

endmodule

// File: rtl/adexp_param_loader.sv
// Host-to-chip parameter write receiver for the AdEx neuron tile.
// Frames are ADDR, DATA_HI, DATA_LO, plus a CHK byte (ADDR^HI^LO) when the
// macro ADEXP_PARAM_CRC_EN is defined.
module adexp_param_loader
    import adexp_pkg::*;
#(
    parameter int NUM_PARAMS  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         wr_strobe,
    input  logic [7:0]                   data_in,
    output logic [NUM_PARAMS*PARAM_W-1:0] params,
    output logic                         upd_pulse,
    output logic [3:0]                   upd_idx,
    output logic                         busy,
    output logic [1:0]                   err
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`ifdef ADEXP_PARAM_CRC_EN
    localparam logic [1:0]       DISC_LAST = 2'd2;
`else
    localparam logic [1:0]       DISC_LAST = 2'd1;
`endif

    state_t             state;
    err_t               err_q;
    logic [CNT_W-1:0]   tcnt;
    logic [1:0]         disc_cnt;
    logic [3:0]         idx_q;
    logic [7:0]         hi_q;
    logic [PARAM_W-1:0] regs [NUM_PARAMS];
    logic               rise;
    logic               commit_now;
    logic [PARAM_W-1:0] commit_val;

    adexp_strobe_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (wr_strobe),
        .rise     (rise)
    );

`ifdef ADEXP_PARAM_CRC_EN
    logic [7:0] lo_q;
    logic [7:0] chk_acc;
    assign commit_now = ena && rise && (state == ST_CHK_W) && (data_in == chk_acc);
    assign commit_val = {hi_q, lo_q};
`else
    assign commit_now = ena && rise && (state == ST_GOT_H);
    assign commit_val = {hi_q, data_in};
`endif

    // Frame FSM, timeout counter, register file and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            err_q     <= ERR_OK;
            tcnt      <= '0;
            disc_cnt  <= '0;
            idx_q     <= '0;
            hi_q      <= '0;
            upd_pulse <= 1'b0;
            upd_idx   <= '0;
`ifdef ADEXP_PARAM_CRC_EN
            lo_q      <= '0;
            chk_acc   <= '0;
`endif
            // NOTE: the register file is small and must come up with defined values, so it is reset.
            for (int i = 0; i < NUM_PARAMS; i++) regs[i] <= PARAM_RESET[i];
        end else begin
            upd_pulse <= 1'b0;
            if (ena) begin
                if (commit_now) begin
                    for (int i = 0; i < NUM_PARAMS; i++)
                        if (idx_q == 4'(i)) regs[i] <= commit_val;
                    upd_pulse <= 1'b1;
                    upd_idx   <= idx_q;
                    err_q     <= ERR_OK;
                end
                if (rise) begin
                    // An edge always restarts the idle counter, so it beats a timeout.
                    tcnt <= '0;
                    unique case (state)
                        ST_IDLE: begin
                            if (addr_ok(data_in, NUM_PARAMS)) begin
                                idx_q <= data_in[3:0];
                                state <= ST_GOT_A;
                            end else begin
                                err_q    <= ERR_ADDR;
                                disc_cnt <= '0;
                                state    <= ST_DISCARD;
                            end
`ifdef ADEXP_PARAM_CRC_EN
                            chk_acc <= data_in;
`endif
                        end
                        ST_GOT_A: begin
                            hi_q  <= data_in;
                            state <= ST_GOT_H;
`ifdef ADEXP_PARAM_CRC_EN
                            chk_acc <= chk_acc ^ data_in;
`endif
                        end
                        ST_GOT_H: begin
`ifdef ADEXP_PARAM_CRC_EN
                            lo_q    <= data_in;
                            chk_acc <= chk_acc ^ data_in;
                            state   <= ST_CHK_W;
`else
                            state   <= ST_IDLE;
`endif
                        end
                        ST_CHK_W: begin
`ifdef ADEXP_PARAM_CRC_EN
                            if (!commit_now) err_q <= ERR_CHK;
`endif
                            state <= ST_IDLE;
                        end
                        ST_DISCARD: begin
                            if (disc_cnt == DISC_LAST) state <= ST_IDLE;
                            else                       disc_cnt <= disc_cnt + 2'd1;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end else if (state != ST_IDLE) begin
                    if (tcnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        err_q <= ERR_TIMEOUT;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_pack
        assign params[g*PARAM_W +: PARAM_W] = regs[g];
    end

    assign busy = (state != ST_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_adexp_param_loader.sv
// Self-checking bench for adexp_param_loader (NUM_PARAMS=8, TIMEOUT_CYC=1024).
// Honours ADEXP_PARAM_CRC_EN the same way the design does.
module tb_adexp_param_loader;

    localparam int NP = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b1;
    logic            wr_strobe = 1'b0;
    logic [7:0]      data_in = 8'h00;
    logic [NP*16-1:0] params;
    logic            upd_pulse;
    logic [3:0]      upd_idx;
    logic            busy;
    logic [1:0]      err;

    adexp_param_loader #(.NUM_PARAMS(NP), .TIMEOUT_CYC(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_strobe (wr_strobe),
        .data_in   (data_in),
        .params    (params),
        .upd_pulse (upd_pulse),
        .upd_idx   (upd_idx),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Expected reset values, written out independently of the design package.
    localparam logic [15:0] RST_VAL [NP] = '{16'h0040, 16'h0800, 16'h0C80, 16'hFC00,
                                             16'h0200, 16'h0010, 16'h0064, 16'h0A00};

    logic [15:0] exp_p [NP];
    logic [1:0]  exp_err;
    int          pulse_cnt = 0;
    logic [3:0]  last_idx = 4'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Count every cycle upd_pulse is high; a stretched pulse shows up as extra counts.
    always @(negedge clk) begin
        if (upd_pulse) begin
            pulse_cnt++;
            last_idx = upd_idx;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in   = b;
        wr_strobe = 1'b1;
        wait_cyc(6);
        wr_strobe = 1'b0;
        wait_cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] a, h, l, c);
        send_byte(a);
        send_byte(h);
        send_byte(l);
`ifdef ADEXP_PARAM_CRC_EN
        send_byte(c);
`else
        if (c === 8'hxx) $display("unused check byte");
`endif
    endtask

    // Reference behaviour of one complete frame at the transaction level.
    task automatic model_frame(input logic [7:0] a, h, l, c, output bit wrote);
        wrote = 1'b0;
        if (!a[7] || int'(a[3:0]) >= NP) begin
            exp_err = 2'd1;
        end else begin
`ifdef ADEXP_PARAM_CRC_EN
            if (c != (a ^ h ^ l)) exp_err = 2'd3;
            else
`endif
            begin
                exp_p[int'(a[3:0])] = {h, l};
                exp_err = 2'd0;
                wrote = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) exp_p[i] = RST_VAL[i];
        exp_err = 2'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (err !== 2'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err); end
        n_cmp++; if (upd_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got %b want 0", upd_pulse); end
        n_cmp++; if (upd_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", upd_idx); end
        for (int i = 0; i < NP; i++) begin
            n_cmp++;
            if (params[16*i +: 16] !== exp_p[i]) begin
                n_bad++; $display("FAIL reset_param[%0d] got %h want %h", i, params[16*i +: 16], exp_p[i]);
            end
        end
    endtask

    task automatic test_basic_write();
        int p0 = pulse_cnt;
        bit wr;
        model_frame(8'h83, 8'h12, 8'h34, 8'h83 ^ 8'h12 ^ 8'h34, wr);
        send_frame(8'h83, 8'h12, 8'h34, 8'h83 ^ 8'h12 ^ 8'h34);
        n_cmp++; if (params[16*3 +: 16] !== 16'h1234) begin n_bad++; $display("FAIL basic_param3 got %h want 1234", params[16*3 +: 16]); end
        n_cmp++; if (pulse_cnt !== p0 + 1) begin n_bad++; $display("FAIL basic_pulses got %0d want %0d", pulse_cnt - p0, 1); end
        n_cmp++; if (last_idx !== 4'd3) begin n_bad++; $display("FAIL basic_idx got %0d want 3", last_idx); end
        n_cmp++; if (err !== 2'd0) begin n_bad++; $display("FAIL basic_err got %0d want 0", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b want 0", busy); end
    endtask

    task automatic test_bad_addr();
        int p0 = pulse_cnt;
        bit wr;
        model_frame(8'h8F, 8'h11, 8'h22, 8'h8F ^ 8'h11 ^ 8'h22, wr);
        send_frame(8'h8F, 8'h11, 8'h22, 8'h8F ^ 8'h11 ^ 8'h22);
        n_cmp++; if (err !== 2'd1) begin n_bad++; $display("FAIL badaddr_err got %0d want 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badaddr_busy got %b want 0", busy); end
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL badaddr_pulses got %0d want 0", pulse_cnt - p0); end
        for (int i = 0; i < NP; i++) begin
            n_cmp++;
            if (params[16*i +: 16] !== exp_p[i]) begin
                n_bad++; $display("FAIL badaddr_param[%0d] got %h want %h", i, params[16*i +: 16], exp_p[i]);
            end
        end
        model_frame(8'h85, 8'hC0, 8'h01, 8'h85 ^ 8'hC0 ^ 8'h01, wr);
        send_frame(8'h85, 8'hC0, 8'h01, 8'h85 ^ 8'hC0 ^ 8'h01);
        n_cmp++; if (err !== 2'd0) begin n_bad++; $display("FAIL badaddr_clear_err got %0d want 0", err); end
        n_cmp++; if (params[16*5 +: 16] !== 16'hC001) begin n_bad++; $display("FAIL badaddr_follow_param5 got %h want c001", params[16*5 +: 16]); end
    endtask

    task automatic test_timeout();
        int p0 = pulse_cnt;
        send_byte(8'h81);
        send_byte(8'hAA);
        wait_cyc(900);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timeout_early_busy got %b want 1", busy); end
        wait_cyc(200);
        exp_err = 2'd2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy got %b want 0", busy); end
        n_cmp++; if (err !== 2'd2) begin n_bad++; $display("FAIL timeout_err got %0d want 2", err); end
        n_cmp++; if (params[16*1 +: 16] !== exp_p[1]) begin n_bad++; $display("FAIL timeout_param1 got %h want %h", params[16*1 +: 16], exp_p[1]); end
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL timeout_pulses got %0d want 0", pulse_cnt - p0); end
    endtask

    task automatic test_ena();
        int p0 = pulse_cnt;
        bit wr;
        ena = 1'b0;
        send_frame(8'h84, 8'hDE, 8'hAD, 8'h84 ^ 8'hDE ^ 8'hAD);
        wait_cyc(3);
        n_cmp++; if (params[16*4 +: 16] !== exp_p[4]) begin n_bad++; $display("FAIL ena_off_param4 got %h want %h", params[16*4 +: 16], exp_p[4]); end
        n_cmp++; if (pulse_cnt !== p0) begin n_bad++; $display("FAIL ena_off_pulses got %0d want 0", pulse_cnt - p0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ena_off_busy got %b want 0", busy); end
        n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL ena_off_err got %0d want %0d", err, exp_err); end
        ena = 1'b1;
        wait_cyc(4);
        model_frame(8'h80, 8'hBE, 8'hEF, 8'h80 ^ 8'hBE ^ 8'hEF, wr);
        send_frame(8'h80, 8'hBE, 8'hEF, 8'h80 ^ 8'hBE ^ 8'hEF);
        n_cmp++; if (params[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL ena_on_param0 got %h want beef", params[15:0]); end
        n_cmp++; if (pulse_cnt !== p0 + 1) begin n_bad++; $display("FAIL ena_on_pulses got %0d want 1", pulse_cnt - p0); end
        n_cmp++; if (last_idx !== 4'd0) begin n_bad++; $display("FAIL ena_on_idx got %0d want 0", last_idx); end
    endtask

`ifdef ADEXP_PARAM_CRC_EN
    task automatic test_crc();
        int p0 = pulse_cnt;
        bit wr;
        model_frame(8'h82, 8'h00, 8'h05, 8'h87, wr);
        send_frame(8'h82, 8'h00, 8'h05, 8'h87);
        n_cmp++; if (params[16*2 +: 16] !== 16'h0005) begin n_bad++; $display("FAIL crc_good_param2 got %h want 0005", params[16*2 +: 16]); end
        n_cmp++; if (pulse_cnt !== p0 + 1) begin n_bad++; $display("FAIL crc_good_pulses got %0d want 1", pulse_cnt - p0); end
        model_frame(8'h82, 8'h00, 8'h06, 8'h00, wr);
        send_frame(8'h82, 8'h00, 8'h06, 8'h00);
        n_cmp++; if (params[16*2 +: 16] !== 16'h0005) begin n_bad++; $display("FAIL crc_bad_param2 got %h want 0005", params[16*2 +: 16]); end
        n_cmp++; if (err !== 2'd3) begin n_bad++; $display("FAIL crc_bad_err got %0d want 3", err); end
        n_cmp++; if (pulse_cnt !== p0 + 1) begin n_bad++; $display("FAIL crc_bad_pulses got %0d want 1", pulse_cnt - p0); end
    endtask
`endif

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            logic [7:0] a, h, l, c;
            int p0 = pulse_cnt;
            bit wr;
            a = {($urandom_range(0, 7) != 0), 3'($urandom), 4'($urandom_range(0, 9))};
            h = 8'($urandom);
            l = 8'($urandom);
            c = a ^ h ^ l;
`ifdef ADEXP_PARAM_CRC_EN
            if ($urandom_range(0, 4) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
`endif
            model_frame(a, h, l, c, wr);
            send_frame(a, h, l, c);
            n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL b2b[%0d]_err addr=%h got %0d want %0d", n, a, err, exp_err); end
            n_cmp++; if (pulse_cnt !== p0 + int'(wr)) begin n_bad++; $display("FAIL b2b[%0d]_pulses got %0d want %0d", n, pulse_cnt - p0, int'(wr)); end
            if (wr) begin
                n_cmp++; if (last_idx !== a[3:0]) begin n_bad++; $display("FAIL b2b[%0d]_idx got %0d want %0d", n, last_idx, a[3:0]); end
            end
            for (int i = 0; i < NP; i++) begin
                n_cmp++;
                if (params[16*i +: 16] !== exp_p[i]) begin
                    n_bad++; $display("FAIL b2b[%0d]_param[%0d] got %h want %h", n, i, params[16*i +: 16], exp_p[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit wr;
        send_byte(8'h83);
        send_byte(8'h55);
        rst_n = 1'b0;
        model_reset();
        wait_cyc(2);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        for (int i = 0; i < NP; i++) begin
            n_cmp++;
            if (params[16*i +: 16] !== exp_p[i]) begin
                n_bad++; $display("FAIL midrst_param[%0d] got %h want %h", i, params[16*i +: 16], exp_p[i]);
            end
        end
        rst_n = 1'b1;
        wait_cyc(4);
        model_frame(8'h86, 8'h7A, 8'h5C, 8'h86 ^ 8'h7A ^ 8'h5C, wr);
        send_frame(8'h86, 8'h7A, 8'h5C, 8'h86 ^ 8'h7A ^ 8'h5C);
        n_cmp++; if (params[16*6 +: 16] !== 16'h7A5C) begin n_bad++; $display("FAIL midrst_after_param6 got %h want 7a5c", params[16*6 +: 16]); end
        n_cmp++; if (params[16*3 +: 16] !== exp_p[3]) begin n_bad++; $display("FAIL midrst_after_param3 got %h want %h", params[16*3 +: 16], exp_p[3]); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_bad_addr();
        test_timeout();
        test_ena();
`ifdef ADEXP_PARAM_CRC_EN
        test_crc();
`endif
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
